// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported pipelined main memory between I-cache and D-cache fills,
// buffering D-cache write-through stores and steering read returns by a tag pipe.
module mem_arbiter #(
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_enable,
  input  logic [15:0] i_memory_address,
  output logic        i_memory_data_valid,
  input  logic        d_mem_enable,
  input  logic        d_mem_write,
  input  logic [15:0] d_memory_address,
  input  logic [15:0] d_data_in,
  output logic        d_memory_data_valid,
  output logic        wb_full,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  input  logic        memory_data_valid
);

  localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);
  localparam logic        OWNER_I = 1'b0;
  localparam logic        OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_OWN = 2'd1,
    D_OWN = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic [15:0]      r_wb_addr [WB_DEPTH];
  logic [15:0]      r_wb_data [WB_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [LATENCY-1:0] r_pipe_vld;
  logic [LATENCY-1:0] r_pipe_own;

  logic             w_owner_phase;
  logic             w_owner_en;
  logic [15:0]      w_owner_addr;
  logic             w_issue_rd;
  logic             w_issue_wr;
  logic             w_push;
  logic             w_wb_drained;
  logic [LATENCY:0] w_pipe_vld_shift;
  logic [LATENCY:0] w_pipe_own_shift;

  assign w_owner_phase = (r_state == I_OWN) || (r_state == D_OWN);
  assign w_owner_en    = (r_state == I_OWN) ? i_mem_enable :
                         (r_state == D_OWN) ? d_mem_enable : 1'b0;
  assign w_owner_addr  = (r_state == I_OWN) ? i_memory_address : d_memory_address;

  // Stores only go out while no fill burst owns the memory port.
  assign w_issue_rd = w_owner_en;
  assign w_issue_wr = !w_owner_phase && (r_count != '0);
  assign w_push     = d_mem_write && !wb_full;

  // Buffer is empty once this cycle's pop (if any) retires the last entry.
  assign w_wb_drained = (r_count == CNT_W'(w_issue_wr));

  assign wb_full    = (r_count == CNT_W'(WB_DEPTH));
  assign mem_enable = w_issue_rd || w_issue_wr;
  assign mem_wr     = w_issue_wr;

  always_comb begin
    mem_addr     = 16'h0000;
    mem_data_out = 16'h0000;
    if (w_issue_wr) begin
      mem_addr     = r_wb_addr[r_rd_ptr];
      mem_data_out = r_wb_data[r_rd_ptr];
    end else if (w_issue_rd) begin
      mem_addr = w_owner_addr;
    end
  end

  // Head of the tag pipe names the requester of the read returning this cycle.
  assign i_memory_data_valid = memory_data_valid && r_pipe_vld[LATENCY-1] &&
                               (r_pipe_own[LATENCY-1] == OWNER_I);
  assign d_memory_data_valid = memory_data_valid && r_pipe_vld[LATENCY-1] &&
                               (r_pipe_own[LATENCY-1] == OWNER_D);

  assign w_pipe_vld_shift = {r_pipe_vld, w_issue_rd};
  assign w_pipe_own_shift = {r_pipe_own, (r_state == D_OWN) ? OWNER_D : OWNER_I};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (d_mem_enable && w_wb_drained) begin
            r_state <= D_OWN;
          end else if (i_mem_enable && !d_mem_enable) begin
            r_state <= I_OWN;
          end
        end
        I_OWN, D_OWN: begin
          if (!w_owner_en) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_pipe_vld == '0) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_own <= '0;
    end else begin
      r_pipe_vld <= w_pipe_vld_shift[LATENCY-1:0];
      r_pipe_own <= w_pipe_own_shift[LATENCY-1:0];
    end
  end

  // Write-buffer pointers and occupancy; a store arriving while full is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      end
      if (w_issue_wr) begin
        r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      end
      if (w_push && !w_issue_wr) begin
        r_count <= CNT_W'(r_count + 1'b1);
      end else if (!w_push && w_issue_wr) begin
        r_count <= CNT_W'(r_count - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= d_memory_address;
      r_wb_data[r_wr_ptr] <= d_data_in;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int LAT = 4;
  localparam int WBD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_enable;
  logic [15:0] i_memory_address;
  logic        i_memory_data_valid;
  logic        d_mem_enable;
  logic        d_mem_write;
  logic [15:0] d_memory_address;
  logic [15:0] d_data_in;
  logic        d_memory_data_valid;
  logic        wb_full;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        memory_data_valid;

  mem_arbiter #(.LATENCY(LAT), .WB_DEPTH(WBD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_mem_enable        (i_mem_enable),
    .i_memory_address    (i_memory_address),
    .i_memory_data_valid (i_memory_data_valid),
    .d_mem_enable        (d_mem_enable),
    .d_mem_write         (d_mem_write),
    .d_memory_address    (d_memory_address),
    .d_data_in           (d_data_in),
    .d_memory_data_valid (d_memory_data_valid),
    .wb_full             (wb_full),
    .mem_enable          (mem_enable),
    .mem_wr              (mem_wr),
    .mem_addr            (mem_addr),
    .mem_data_out        (mem_data_out),
    .memory_data_valid   (memory_data_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: store queue, current owner, and issue cycles of reads in flight.
  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } st_t;

  st_t   wbq[$];
  st_t   m_ent;
  int    grant = 0;      // 0 none, 1 I-cache, 2 D-cache
  bit    draining = 0;
  int    rd_cyc[$];
  int    rd_own[$];
  int    cyc = 0;
  bit    m_owner_phase, m_own_en, m_rd, m_wr, m_busy;
  int    m_ret, m_before;
  logic [15:0] m_addr, m_data;

  // Observed-trace bookkeeping for directed literal checks.
  int    cnt_rd, cnt_wr, cnt_iv, cnt_dv;
  int    first_rd_cyc, first_i_rd_cyc, last_wr_cyc;
  logic [15:0] first_rd_addr;
  logic [15:0] wlog_a[$];
  logic [15:0] wlog_d[$];

  // Memory echo: reads seen on the port come back LAT cycles later.
  logic [LAT-1:0] hist = '0;
  bit spur_en = 0;

  initial begin : mem_model
    memory_data_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      memory_data_valid = hist[LAT-1] | (spur_en && ($urandom_range(7) == 0));
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      hist = {hist[LAT-2:0], mem_enable & ~mem_wr};
      if (rst) begin
        chk("rst_mem_enable", mem_enable, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data_out", mem_data_out, 0);
        chk("rst_i_valid", i_memory_data_valid, 0);
        chk("rst_d_valid", d_memory_data_valid, 0);
        chk("rst_wb_full", wb_full, 0);
        wbq.delete();
        rd_cyc.delete();
        rd_own.delete();
        grant = 0;
        draining = 0;
      end else begin
        m_owner_phase = (grant != 0) && !draining;
        m_own_en = (grant == 1) ? i_mem_enable : (grant == 2) ? d_mem_enable : 1'b0;
        m_rd = m_owner_phase && m_own_en;
        m_wr = !m_owner_phase && (wbq.size() > 0);
        m_addr = 16'h0000;
        m_data = 16'h0000;
        if (m_wr) begin
          m_addr = wbq[0].a;
          m_data = wbq[0].d;
        end else if (m_rd) begin
          m_addr = (grant == 1) ? i_memory_address : d_memory_address;
        end
        m_ret = 0;
        m_busy = 0;
        foreach (rd_cyc[k]) begin
          if (rd_cyc[k] == cyc - LAT) m_ret = rd_own[k];
          if (rd_cyc[k] >= cyc - LAT && rd_cyc[k] <= cyc - 1) m_busy = 1;
        end
        chk("mem_enable", mem_enable, m_rd | m_wr);
        chk("mem_wr", mem_wr, m_wr);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data_out", mem_data_out, m_data);
        chk("i_valid", i_memory_data_valid, memory_data_valid && (m_ret == 1));
        chk("d_valid", d_memory_data_valid, memory_data_valid && (m_ret == 2));
        chk("wb_full", wb_full, wbq.size() == WBD);

        if (mem_enable && !mem_wr) begin
          cnt_rd++;
          if (first_rd_cyc < 0) begin
            first_rd_cyc = cyc;
            first_rd_addr = mem_addr;
          end
          if (first_i_rd_cyc < 0 && mem_addr == 16'h4000) first_i_rd_cyc = cyc;
        end
        if (mem_enable && mem_wr) begin
          cnt_wr++;
          last_wr_cyc = cyc;
          wlog_a.push_back(mem_addr);
          wlog_d.push_back(mem_data_out);
        end
        if (i_memory_data_valid) cnt_iv++;
        if (d_memory_data_valid) cnt_dv++;

        m_before = wbq.size();
        if (m_rd) begin
          rd_cyc.push_back(cyc);
          rd_own.push_back(grant);
        end
        if (m_wr) void'(wbq.pop_front());
        if (d_mem_write && m_before != WBD) begin
          m_ent.a = d_memory_address;
          m_ent.d = d_data_in;
          wbq.push_back(m_ent);
        end
        if (grant == 0) begin
          if (d_mem_enable && (m_before - int'(m_wr)) == 0) grant = 2;
          else if (i_mem_enable && !d_mem_enable) grant = 1;
        end else if (!draining) begin
          if (!m_own_en) draining = 1;
        end else if (!m_busy) begin
          grant = 0;
          draining = 0;
        end
        while (rd_cyc.size() > 0 && rd_cyc[0] <= cyc - LAT) begin
          void'(rd_cyc.pop_front());
          void'(rd_own.pop_front());
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_mem_enable = 1'b0;
    d_mem_enable = 1'b0;
    d_mem_write  = 1'b0;
  endtask

  task automatic clr();
    cnt_rd = 0; cnt_wr = 0; cnt_iv = 0; cnt_dv = 0;
    first_rd_cyc = -1; first_i_rd_cyc = -1; last_wr_cyc = -1;
    first_rd_addr = 16'h0000;
    wlog_a.delete();
    wlog_d.delete();
  endtask

  logic [15:0] b_dat [3];
  logic [15:0] exp16;
  int t0;

  initial begin : stimulus
    b_dat[0] = 16'hAAAA; b_dat[1] = 16'hBBBB; b_dat[2] = 16'hCCCC;
    rst = 1'b1;
    idle_inputs();
    i_memory_address = 16'h0000;
    d_memory_address = 16'h0000;
    d_data_in = 16'h0000;
    clr();
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // I burst: 8 reads at 0x0100..0x010E, first one the cycle after the request.
    clr();
    for (int k = 0; k < 9; k++) begin
      i_mem_enable = 1'b1;
      i_memory_address = (k == 0) ? 16'h0100 : 16'(16'h0100 + 2 * (k - 1));
      @(negedge clk);
      if (k == 0) chk("A_no_access_on_request", mem_enable, 0);
      if (k == 1) begin
        chk("A_grant_next_cycle", mem_enable, 1);
        chk("A_first_addr", mem_addr, 16'h0100);
      end
      step();
    end
    i_mem_enable = 1'b0;
    repeat (8) step();
    chk("A_reads", cnt_rd, 8);
    chk("A_i_valids", cnt_iv, 8);
    chk("A_d_valids", cnt_dv, 0);
    chk("A_model_idle", grant, 0);

    // Three stores, then a D fill that must wait behind them.
    clr();
    for (int k = 0; k < 3; k++) begin
      d_mem_write = 1'b1;
      d_memory_address = 16'(16'h2000 + 2 * k);
      d_data_in = b_dat[k];
      step();
    end
    d_mem_write = 1'b0;
    d_mem_enable = 1'b1;
    d_memory_address = 16'h2000;
    repeat (5) step();
    d_mem_enable = 1'b0;
    repeat (8) step();
    chk("B_writes", cnt_wr, 3);
    for (int k = 0; k < 3; k++) begin
      exp16 = 16'(16'h2000 + 2 * k);
      chk("B_wr_addr", (wlog_a.size() > k) ? wlog_a[k] : 16'hxxxx, exp16);
      chk("B_wr_data", (wlog_d.size() > k) ? wlog_d[k] : 16'hxxxx, b_dat[k]);
    end
    chk("B_writes_before_read", last_wr_cyc < first_rd_cyc, 1);
    chk("B_reads", cnt_rd, 4);
    chk("B_d_valids", cnt_dv, 4);
    chk("B_i_valids", cnt_iv, 0);

    // Simultaneous requests: D first, I only after D drains.
    clr();
    t0 = cyc;
    i_mem_enable = 1'b1; i_memory_address = 16'h4000;
    d_mem_enable = 1'b1; d_memory_address = 16'h3000;
    repeat (4) step();
    d_mem_enable = 1'b0;
    repeat (8) step();
    i_mem_enable = 1'b0;
    repeat (8) step();
    chk("C_first_read_cycle", first_rd_cyc, t0 + 1);
    chk("C_first_read_is_D", first_rd_addr, 16'h3000);
    chk("C_first_I_read_cycle", first_i_rd_cyc, t0 + 10);
    chk("C_d_valids", cnt_dv, 3);
    chk("C_i_valids", cnt_iv, 2);

    // Five stores during an I burst: 4 kept, 5th dropped, drained in order afterwards.
    clr();
    i_mem_enable = 1'b1;
    i_memory_address = 16'h0200;
    step();
    for (int k = 0; k < 5; k++) begin
      d_mem_write = 1'b1;
      d_memory_address = 16'(16'h5000 + 2 * k);
      d_data_in = 16'(16'h5A00 + k);
      @(negedge clk);
      if (k == 3) chk("D_not_full_before_4th", wb_full, 0);
      if (k == 4) chk("D_full_after_4th", wb_full, 1);
      step();
    end
    d_mem_write = 1'b0;
    repeat (2) step();
    i_mem_enable = 1'b0;
    repeat (12) step();
    chk("D_writes", cnt_wr, 4);
    for (int k = 0; k < 4; k++) begin
      exp16 = 16'(16'h5000 + 2 * k);
      chk("D_wr_addr", (wlog_a.size() > k) ? wlog_a[k] : 16'hxxxx, exp16);
      exp16 = 16'(16'h5A00 + k);
      chk("D_wr_data", (wlog_d.size() > k) ? wlog_d[k] : 16'hxxxx, exp16);
    end
    chk("D_reads", cnt_rd, 7);
    chk("D_i_valids", cnt_iv, 7);
    chk("D_full_cleared", wb_full, 0);
    chk("D_model_wb_empty", wbq.size(), 0);

    // Store during a D burst issues in DRAIN alongside returning reads.
    clr();
    t0 = cyc;
    d_mem_enable = 1'b1;
    d_memory_address = 16'h6000;
    repeat (2) step();
    d_mem_write = 1'b1;
    d_memory_address = 16'h6100;
    d_data_in = 16'h1234;
    step();
    d_mem_write = 1'b0;
    d_memory_address = 16'h6000;
    step();
    d_mem_enable = 1'b0;
    repeat (10) step();
    chk("E_reads", cnt_rd, 3);
    chk("E_d_valids", cnt_dv, 3);
    chk("E_i_valids", cnt_iv, 0);
    chk("E_writes", cnt_wr, 1);
    chk("E_wr_addr", (wlog_a.size() > 0) ? wlog_a[0] : 16'hxxxx, 16'h6100);
    chk("E_wr_data", (wlog_d.size() > 0) ? wlog_d[0] : 16'hxxxx, 16'h1234);
    chk("E_wr_cycle", last_wr_cyc, t0 + 5);

    // Mid-cycle reset with an I burst running and stores buffered.
    i_mem_enable = 1'b1;
    i_memory_address = 16'h7000;
    step();
    d_mem_write = 1'b1; d_memory_address = 16'h7100; d_data_in = 16'h0F0F;
    step();
    d_memory_address = 16'h7102;
    step();
    d_mem_write = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("R_mem_enable", mem_enable, 0);
    chk("R_mem_wr", mem_wr, 0);
    chk("R_mem_addr", mem_addr, 0);
    chk("R_mem_data_out", mem_data_out, 0);
    chk("R_i_valid", i_memory_data_valid, 0);
    chk("R_wb_full", wb_full, 0);
    idle_inputs();
    step();
    rst = 1'b0;
    clr();
    repeat (8) step();
    chk("R_no_stale_writes", cnt_wr, 0);
    chk("R_stale_returns_ignored", cnt_iv + cnt_dv, 0);

    // Randomized traffic against the model.
    spur_en = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) i_mem_enable = ~i_mem_enable;
      if ($urandom_range(7) == 0) d_mem_enable = ~d_mem_enable;
      i_memory_address = 16'($urandom);
      d_memory_address = 16'($urandom);
      d_data_in = 16'($urandom);
      d_mem_write = ($urandom_range(3) == 0);
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    spur_en = 0;
    repeat (20) step();
    chk("final_model_idle", grant, 0);
    chk("final_wb_full", wb_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
